// File: rtl/tile_scan_if.sv
// Handshake bundle between the tile scanner, the triangle setup source,
// the tile evaluator and the pixel consumer.
interface tile_scan_if #(
  parameter int XW = 5,
  parameter int YW = 5
);
  logic          tri_valid;
  logic          tri_ready;
  logic [53:0]   tri_a;
  logic [53:0]   tri_b;
  logic [53:0]   tri_c;
  logic [53:0]   tile_a;
  logic [53:0]   tile_b;
  logic [53:0]   tile_c;
  logic [1:0]    tile_cmd;
  logic          tile_inside;
  logic          pix_valid;
  logic          pix_ready;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          pix_last;
  logic          done;
  logic [15:0]   covered;

  // Environment side: setup source, evaluator flag, pixel consumer.
  modport master (
    output tri_valid, tri_a, tri_b, tri_c, tile_inside, pix_ready,
    input  tri_ready, tile_a, tile_b, tile_c, tile_cmd,
           pix_valid, pix_x, pix_y, pix_last, done, covered
  );

  // Scanner side.
  modport slave (
    input  tri_valid, tri_a, tri_b, tri_c, tile_inside, pix_ready,
    output tri_ready, tile_a, tile_b, tile_c, tile_cmd,
           pix_valid, pix_x, pix_y, pix_last, done, covered
  );
endinterface

// File: rtl/tile_scan.sv
// Raster scanner for one tile: latches a triangle's edge coefficients, drives
// the tile evaluator with restart/stepx/stepy commands in lock-step with its
// own x/y counters, and forwards covered pixels under valid/ready.
module tile_scan #(
  parameter int XW = 5,
  parameter int YW = 5
) (
  input  logic         clock,
  input  logic         reset,
  tile_scan_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, LOAD, SCAN} state_t;

  localparam logic [1:0] CMD_NOP     = 2'd0;
  localparam logic [1:0] CMD_RESTART = 2'd1;
  localparam logic [1:0] CMD_STEPY   = 2'd2;
  localparam logic [1:0] CMD_STEPX   = 2'd3;

  localparam logic [XW-1:0] X_MAX = '1;
  localparam logic [YW-1:0] Y_MAX = '1;

  state_t        r_state, w_next;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [15:0]   r_cov;
  logic [53:0]   r_a, r_b, r_c;

  logic       w_pix_valid;
  logic       w_adv;
  logic       w_done;
  logic [1:0] w_cmd;
  logic       w_x_max, w_y_max;

  assign w_x_max = (r_x == X_MAX);
  assign w_y_max = (r_y == Y_MAX);

  // Next state, evaluator command and pixel handshake; the command is
  // combinational so the evaluator steps on the same edge as x/y.
  always_comb begin
    w_next      = r_state;
    w_cmd       = CMD_NOP;
    w_done      = 1'b0;
    w_pix_valid = 1'b0;
    w_adv       = 1'b0;
    unique case (r_state)
      IDLE: if (bus.tri_valid) w_next = LOAD;
      LOAD: begin
        w_cmd  = CMD_RESTART;
        w_next = SCAN;
      end
      SCAN: begin
        w_pix_valid = bus.tile_inside;
        w_adv       = !w_pix_valid || bus.pix_ready;
        if (w_adv) begin
          if (!w_x_max)      w_cmd = CMD_STEPX;
          else if (!w_y_max) w_cmd = CMD_STEPY;
          else begin
            w_done = 1'b1;
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
    // Reset forces a quiet interface even before the first reset edge.
    if (reset) begin
      w_cmd       = CMD_NOP;
      w_done      = 1'b0;
      w_pix_valid = 1'b0;
      w_adv       = 1'b0;
      w_next      = IDLE;
    end
  end

  // State, coefficient latch, raster counters and coverage count.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_cov   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.tri_valid) begin
        r_a   <= bus.tri_a;
        r_b   <= bus.tri_b;
        r_c   <= bus.tri_c;
        r_cov <= '0;
      end
      if (r_state == LOAD) begin
        r_x <= '0;
        r_y <= '0;
      end
      if (w_adv) begin
        if (!w_x_max) begin
          r_x <= r_x + XW'(1);
        end else if (!w_y_max) begin
          r_x <= '0;
          r_y <= r_y + YW'(1);
        end
      end
      if (w_pix_valid && bus.pix_ready && r_cov != 16'hFFFF)
        r_cov <= r_cov + 16'd1;
    end
  end

  assign bus.tri_ready = (r_state == IDLE);
  assign bus.tile_a    = r_a;
  assign bus.tile_b    = r_b;
  assign bus.tile_c    = r_c;
  assign bus.tile_cmd  = w_cmd;
  assign bus.pix_valid = w_pix_valid;
  assign bus.pix_x     = r_x;
  assign bus.pix_y     = r_y;
  assign bus.pix_last  = (r_state == SCAN) && w_x_max && w_y_max;
  assign bus.done      = w_done;
  assign bus.covered   = r_cov;
endmodule

// File: tb/tb_tile_scan.sv
// Scoreboard bench for tile_scan: directed triangle setups, a behavioural
// edge evaluator, and a monitor popping expected pixels as they are accepted.
module tb_tile_scan;
  localparam int XW = 5;
  localparam int YW = 5;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  tile_scan_if #(.XW(XW), .YW(YW)) bus();

  tile_scan #(.XW(XW), .YW(YW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [10:0] q[$];   // {last, y, x}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Edge evaluator: restart loads origin, stepy walks the row start by b,
  // stepx walks the current value by a; inside when every edge is >= 0.
  logic signed [17:0] ev_row[3];
  logic signed [17:0] ev_e[3];
  always @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      case (bus.tile_cmd)
        2'd1: begin
          ev_row[k] <= $signed(bus.tile_c[18*k +: 18]);
          ev_e[k]   <= $signed(bus.tile_c[18*k +: 18]);
        end
        2'd2: begin
          ev_row[k] <= ev_row[k] + $signed(bus.tile_b[18*k +: 18]);
          ev_e[k]   <= ev_row[k] + $signed(bus.tile_b[18*k +: 18]);
        end
        2'd3: ev_e[k] <= ev_e[k] + $signed(bus.tile_a[18*k +: 18]);
        default: ;
      endcase
    end
  end
  always_comb bus.tile_inside = (ev_e[0] >= 0) && (ev_e[1] >= 0) && (ev_e[2] >= 0);

  // Monitor: every accepted pixel must match the head of the queue.
  always @(negedge clock) begin
    if (!reset && bus.pix_valid && bus.pix_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pixel: got x=%0d y=%0d expected none", bus.pix_x, bus.pix_y);
      end else begin
        logic [10:0] e;
        e = q.pop_front();
        check("pixel", {bus.pix_last, bus.pix_y, bus.pix_x}, e);
      end
    end
  end

  // Expected raster: columns 0..xlim-1 covered in every row.
  task automatic push_exp(input int xlim);
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < xlim; x++)
        q.push_back({(x == 31 && y == 31) ? 1'b1 : 1'b0, 5'(y), 5'(x)});
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1 in LOAD.
  task automatic accept(input logic [53:0] a, input logic [53:0] b, input logic [53:0] c);
    int w;
    bus.tri_valid = 1'b1;
    bus.tri_a = a;
    bus.tri_b = b;
    bus.tri_c = c;
    w = 0;
    while (!bus.tri_ready && w < 2000) begin
      @(posedge clock); #1;
      w++;
    end
    check("tri_ready_wait", (w < 2000), 1);
    @(posedge clock); #1;
    bus.tri_valid = 1'b0;
  endtask

  // Called in the LOAD cycle; returns at posedge+1 of the cycle after done.
  task automatic run(input int xlim, input int stall, input int exp_cyc,
                     input logic chk_stable, input logic [53:0] sa,
                     input logic [53:0] sb, input logic [53:0] sc);
    int   n;
    logic d;
    logic stable;
    n = 0;
    d = 1'b0;
    stable = 1'b1;
    bus.pix_ready = (stall == 0);
    while (!d && n < 3000) begin
      @(negedge clock);
      n++;
      d = bus.done;
      if (n == 1) check("load_cmd", bus.tile_cmd, 1);
      if (stall == 0 && n == 2)  check("stepx_cmd", bus.tile_cmd, 3);
      if (stall == 0 && n == 33) check("stepy_cmd", bus.tile_cmd, 2);
      if (stall > 0 && n >= 2 && n <= 1 + stall) begin
        check("stall_cmd", bus.tile_cmd, 0);
        check("stall_xy", {bus.pix_y, bus.pix_x}, 0);
      end
      if (chk_stable && (bus.tile_a !== sa || bus.tile_b !== sb || bus.tile_c !== sc))
        stable = 1'b0;
      @(posedge clock); #1;
      if (n >= 1 + stall) bus.pix_ready = 1'b1;
    end
    check("scan_cycles", n, exp_cyc);
    check("covered", bus.covered, xlim * 32);
    check("queue_empty", q.size(), 0);
    check("done_one_cycle", bus.done, 0);
    if (chk_stable) check("coef_stable", stable, 1);
  endtask

  localparam logic [53:0] ZERO  = 54'd0;
  localparam logic [53:0] C1    = {18'd1, 18'd1, 18'd1};
  localparam logic [53:0] C2    = {18'd2, 18'd2, 18'd2};
  localparam logic [53:0] CNEG  = {18'd1, 18'd1, 18'h3FFFF};
  localparam logic [53:0] AHALF = {18'd0, 18'd0, 18'h3FFFF};
  localparam logic [53:0] CHALF = {18'd1, 18'd1, 18'd15};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic seen;
    reset = 1'b1;
    bus.tri_valid = 1'b1;
    bus.tri_a = C1;
    bus.tri_b = C1;
    bus.tri_c = C1;
    bus.pix_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_tri_ready", bus.tri_ready, 1);
    check("rst_cmd", bus.tile_cmd, 0);
    check("rst_pix_valid", bus.pix_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_covered", bus.covered, 0);
    check("rst_tile_c", bus.tile_c, 0);
    check("rst_xy", {bus.pix_y, bus.pix_x}, 0);
    bus.tri_valid = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;

    // Full cover.
    push_exp(32);
    accept(ZERO, ZERO, C1);
    run(32, 0, 1025, 1'b0, ZERO, ZERO, ZERO);

    // Edge 0 negative everywhere: nothing covered, done still pulses.
    push_exp(0);
    accept(ZERO, ZERO, CNEG);
    run(0, 0, 1025, 1'b0, ZERO, ZERO, ZERO);

    // Left half of each row.
    push_exp(16);
    accept(AHALF, ZERO, CHALF);
    run(16, 0, 1025, 1'b0, ZERO, ZERO, ZERO);

    // Full cover with three stall cycles on the first pixel.
    push_exp(32);
    accept(ZERO, ZERO, C1);
    run(32, 3, 1028, 1'b0, ZERO, ZERO, ZERO);

    // Reset in the middle of a scan at (5,7).
    push_exp(32);
    accept(ZERO, ZERO, C1);
    w = 0;
    while (!(bus.pix_x == 5 && bus.pix_y == 7) && w < 2000) begin
      @(posedge clock); #1;
      w++;
    end
    check("reach_5_7", (w < 2000), 1);
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_done", bus.done, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    q.delete();
    check("rst_mid_ready", bus.tri_ready, 1);
    check("rst_mid_covered", bus.covered, 0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (bus.done || bus.pix_valid) seen = 1'b1;
    end
    check("rst_mid_quiet", seen, 0);
    @(posedge clock); #1;

    // Second setup offered throughout a scan.
    push_exp(32);
    accept(ZERO, ZERO, C1);
    bus.tri_valid = 1'b1;
    bus.tri_a = ZERO;
    bus.tri_b = ZERO;
    bus.tri_c = C2;
    run(32, 0, 1025, 1'b1, ZERO, ZERO, C1);
    check("second_ready", bus.tri_ready, 1);
    push_exp(32);
    @(posedge clock); #1;
    bus.tri_valid = 1'b0;
    check("second_latched", bus.tile_c, C2);
    run(32, 0, 1025, 1'b0, ZERO, ZERO, ZERO);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
